// File: rtl/chan_scan_mux.sv
// Registered N-channel multiplexer with manual select and round-robin scan.
// All outputs are registered; hold freezes every piece of state.
module chan_scan_mux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*WIDTH-1:0]   din,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   mode,
    input  logic                   hold,
    output logic [WIDTH-1:0]       dout,
    output logic [SEL_W-1:0]       ch,
    output logic                   ch_chg,
    output logic                   sel_err
);

    localparam logic [0:0]       ST_MANUAL = 1'b0;
    localparam logic [0:0]       ST_SCAN   = 1'b1;
    localparam int               NSLOT     = 2 ** SEL_W;
    localparam logic [SEL_W:0]   NCH_W     = (SEL_W + 1)'(NCH);
    localparam logic [SEL_W-1:0] CH_LAST   = SEL_W'(NCH - 1);
    localparam logic [15:0]      DWELL_M1  = 16'(DWELL - 1);

    logic [0:0]       state_r;
    logic [0:0]       state_nx_s;
    logic [SEL_W-1:0] ch_r;
    logic [SEL_W-1:0] ch_nx_s;
    logic [15:0]      cnt_r;
    logic [15:0]      cnt_nx_s;
    logic [WIDTH-1:0] dout_r;
    logic [WIDTH-1:0] dout_nx_s;
    logic             ch_chg_r;
    logic             sel_err_r;
    logic             sel_err_nx_s;
    logic             sel_ok_s;
    logic [WIDTH-1:0] chan_s [NSLOT];

    // Unused index slots (NCH not a power of two) read as zero and are never selected.
    for (genvar k = 0; k < NSLOT; k++) begin : g_chan
        if (k < NCH) begin : g_used
            assign chan_s[k] = din[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chan_s[k] = {WIDTH{1'b0}};
        end
    end

    assign sel_ok_s = ({1'b0, sel} < NCH_W);

    // Next-state decode: hold beats mode; mode 0 always lands in MANUAL.
    always_comb begin
        state_nx_s   = state_r;
        ch_nx_s      = ch_r;
        cnt_nx_s     = cnt_r;
        sel_err_nx_s = 1'b0;
        if (hold) begin
            state_nx_s = state_r;
        end else if (!mode) begin
            state_nx_s = ST_MANUAL;
            cnt_nx_s   = 16'd0;
            if (sel_ok_s) begin
                ch_nx_s = sel;
            end else begin
                ch_nx_s      = ch_r;
                sel_err_nx_s = 1'b1;
            end
        end else begin
            case (state_r)
                ST_MANUAL: begin
                    state_nx_s = ST_SCAN;
                    cnt_nx_s   = 16'd0;
                end
                ST_SCAN: begin
                    if (cnt_r == DWELL_M1) begin
                        cnt_nx_s = 16'd0;
                        if (ch_r == CH_LAST) begin
                            ch_nx_s = {SEL_W{1'b0}};
                        end else begin
                            ch_nx_s = ch_r + {{(SEL_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        cnt_nx_s = cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_nx_s = ST_MANUAL;
                    cnt_nx_s   = 16'd0;
                end
            endcase
        end
    end

    // Data follows the channel being selected this cycle, not the old one.
    always_comb begin
        if (hold) begin
            dout_nx_s = dout_r;
        end else begin
            dout_nx_s = chan_s[ch_nx_s];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_MANUAL;
            ch_r      <= {SEL_W{1'b0}};
            cnt_r     <= 16'd0;
            dout_r    <= {WIDTH{1'b0}};
            ch_chg_r  <= 1'b0;
            sel_err_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            ch_r      <= ch_nx_s;
            cnt_r     <= cnt_nx_s;
            dout_r    <= dout_nx_s;
            ch_chg_r  <= (ch_nx_s != ch_r);
            sel_err_r <= sel_err_nx_s;
        end
    end

    assign dout    = dout_r;
    assign ch      = ch_r;
    assign ch_chg  = ch_chg_r;
    assign sel_err = sel_err_r;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench: a vector table for the 4-channel instance plus hand
// sequences for 3-channel wrap/out-of-range select and DWELL = 1 scanning.
module tb_chan_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic        hold;
    logic [1:0]  sel;
    logic [31:0] din4 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    logic [23:0] din3 = {8'hC3, 8'hB2, 8'hA1};

    logic [7:0] dout_a, dout_b, dout_c;
    logic [1:0] ch_a, ch_b, ch_c;
    logic       chg_a, chg_b, chg_c;
    logic       err_a, err_b, err_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    chan_scan_mux #(.WIDTH(8), .NCH(4), .SEL_W(2), .DWELL(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel), .mode(mode), .hold(hold),
        .dout(dout_a), .ch(ch_a), .ch_chg(chg_a), .sel_err(err_a));

    chan_scan_mux #(.WIDTH(8), .NCH(3), .SEL_W(2), .DWELL(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel), .mode(mode), .hold(hold),
        .dout(dout_b), .ch(ch_b), .ch_chg(chg_b), .sel_err(err_b));

    chan_scan_mux #(.WIDTH(8), .NCH(4), .SEL_W(2), .DWELL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel), .mode(mode), .hold(hold),
        .dout(dout_c), .ch(ch_c), .ch_chg(chg_c), .sel_err(err_c));

    typedef struct {
        logic       rst_n;
        logic       mode;
        logic       hold;
        logic [1:0] sel;
        logic [1:0] ch;
        logic [7:0] dout;
        logic       chg;
        logic       err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic m, input logic h, input logic [1:0] s,
                       input logic [1:0] c, input logic [7:0] d, input logic g, input logic e);
        vec_t v;
        v.rst_n = r; v.mode = m; v.hold = h; v.sel = s;
        v.ch = c; v.dout = d; v.chg = g; v.err = e;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic m, input logic h, input logic [1:0] s);
        rst_n = r; mode = m; hold = h; sel = s;
    endtask

    logic [7:0] byte4 [4];

    initial begin
        byte4[0] = 8'hA1; byte4[1] = 8'hB2; byte4[2] = 8'hC3; byte4[3] = 8'hD4;
        drive(1'b0, 1'b1, 1'b0, 2'd0);

        // rst mode hold sel | ch dout chg err
        add(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'hA1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 2'd2, 2'd2, 8'hC3, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 2'd2, 2'd2, 8'hC3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b0, 2'd2, 2'd2, 8'hC3, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 2'd0, 2'd3, 8'hD4, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, 2'd0, 2'd3, 8'hD4, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 8'hA1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 8'hA1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 8'hB2, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 8'hB2, 1'b0, 1'b0);
        // hold mid-dwell with mode/sel wiggling underneath
        for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 1'b1, 2'd3, 2'd1, 8'hB2, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 8'hB2, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 8'hB2, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 2'd0, 2'd2, 8'hC3, 1'b1, 1'b0);
        // mode drops while held; transition runs once hold is released
        add(1'b1, 1'b0, 1'b1, 2'd1, 2'd2, 8'hC3, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 2'd1, 2'd2, 8'hC3, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 8'hB2, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 8'hB2, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 8'hB2, 1'b0, 1'b0);
        // reset mid-scan
        add(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'hA1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 2'd3, 2'd3, 8'hD4, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 2'd3, 2'd3, 8'hD4, 1'b0, 1'b0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst_n, vq[i].mode, vq[i].hold, vq[i].sel);
            step();
            chk($sformatf("v%0d_ch", i),   {30'd0, ch_a},   {30'd0, vq[i].ch});
            chk($sformatf("v%0d_dout", i), {24'd0, dout_a}, {24'd0, vq[i].dout});
            chk($sformatf("v%0d_chg", i),  {31'd0, chg_a},  {31'd0, vq[i].chg});
            chk($sformatf("v%0d_err", i),  {31'd0, err_a},  {31'd0, vq[i].err});
        end

        // NCH = 3: out-of-range select, then scan wrap 2 -> 0
        drive(1'b0, 1'b1, 1'b0, 2'd0);
        step();
        chk("n3_rst_ch", {30'd0, ch_b}, 32'd0);
        chk("n3_rst_dout", {24'd0, dout_b}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 2'd1);
        step();
        chk("n3_sel1_ch", {30'd0, ch_b}, 32'd1);
        chk("n3_sel1_chg", {31'd0, chg_b}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 2'd3);
        step();
        chk("n3_oor_ch", {30'd0, ch_b}, 32'd1);
        chk("n3_oor_dout", {24'd0, dout_b}, 32'hB2);
        chk("n3_oor_err", {31'd0, err_b}, 32'd1);
        chk("n3_oor_chg", {31'd0, chg_b}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 2'd2);
        step();
        chk("n3_err_clr", {31'd0, err_b}, 32'd0);
        chk("n3_sel2_ch", {30'd0, ch_b}, 32'd2);
        drive(1'b1, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("n3_dwell%0d_ch", i), {30'd0, ch_b}, 32'd2);
            chk($sformatf("n3_dwell%0d_chg", i), {31'd0, chg_b}, 32'd0);
        end
        step();
        chk("n3_wrap_ch", {30'd0, ch_b}, 32'd0);
        chk("n3_wrap_dout", {24'd0, dout_b}, 32'hA1);
        chk("n3_wrap_chg", {31'd0, chg_b}, 32'd1);

        // DWELL = 1: a step and a ch_chg pulse on every scan cycle
        drive(1'b0, 1'b1, 1'b0, 2'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, 2'd0);
        step();
        chk("d1_entry_ch", {30'd0, ch_c}, 32'd0);
        chk("d1_entry_chg", {31'd0, chg_c}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("d1_s%0d_ch", i), {30'd0, ch_c}, 32'(i % 4));
            chk($sformatf("d1_s%0d_dout", i), {24'd0, dout_c}, {24'd0, byte4[i % 4]});
            chk($sformatf("d1_s%0d_chg", i), {31'd0, chg_c}, 32'd1);
            chk($sformatf("d1_s%0d_err", i), {31'd0, err_c}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
